// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame width,
// and the baud tick divider calculation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    // Rounded clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int den;
        int q;
        den = baud * oversample;
        q   = (clk_hz + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Reset is synchronous, active-low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;

    logic             w_pop;
    logic             w_push;
    logic [PW-1:0]    w_rd_next;
    logic [CW-1:0]    w_left;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_data;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop     = i_pop & ~o_empty;
    assign w_push    = i_push & (~o_full | w_pop);
    assign w_rd_next = r_rd_ptr + PW'(w_pop);
    assign w_left    = r_count - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_left + CW'(w_push);
            // Head comes from memory unless the incoming word becomes the new head.
            if (w_left != '0) begin
                r_data <= r_mem[w_rd_next];
            end else if (w_push) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a byte FIFO on a valid/ready stream.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [DW-1:0]        r_div_cnt;
    logic                 w_tick;

    uart_state_t          r_state;
    uart_state_t          w_state_n;
    logic [TW-1:0]        r_tcnt;
    logic [TW-1:0]        w_tcnt_n;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_bit_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 r_push;
    logic                 w_push_n;
    logic                 r_frame_err;
    logic                 w_frame_err_n;
    logic                 r_overflow;
    logic                 w_centre;
    logic                 w_half;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;

`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 w_par_bad_n;
    logic                 r_parity_err;
    logic                 w_parity_err_n;
`endif

    assign w_tick   = (r_div_cnt == DW'(DIV - 1));
    assign w_centre = (r_tcnt == TW'(OVERSAMPLE - 1));
    assign w_half   = (r_tcnt == TW'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_div_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_div_cnt  <= w_tick ? '0 : r_div_cnt + DW'(1);
            r_overflow <= r_overflow | (r_push & w_full & ~w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_tcnt      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_tcnt      <= w_tcnt_n;
            r_bit       <= w_bit_n;
            r_shift     <= w_shift_n;
            r_push      <= w_push_n;
            r_frame_err <= w_frame_err_n;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_n;
            r_parity_err <= w_parity_err_n;
`endif
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_tcnt_n      = r_tcnt;
        w_bit_n       = r_bit;
        w_shift_n     = r_shift;
        w_push_n      = 1'b0;
        w_frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_n    = r_par_bad;
        w_parity_err_n = 1'b0;
`endif
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        w_state_n = START;
                        w_tcnt_n  = '0;
                    end
                end
                START: begin
                    if (w_half) begin
                        w_tcnt_n  = '0;
                        w_bit_n   = '0;
                        w_state_n = r_rx_s ? IDLE : DATA;
                    end else begin
                        w_tcnt_n = r_tcnt + TW'(1);
                    end
                end
                DATA: begin
                    if (w_centre) begin
                        w_tcnt_n  = '0;
                        w_shift_n = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_n   = r_bit + BW'(1);
                        if (r_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_n = PARITY;
`else
                            w_state_n = STOP;
`endif
                        end
                    end else begin
                        w_tcnt_n = r_tcnt + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_centre) begin
                        w_tcnt_n       = '0;
                        w_par_bad_n    = (^r_shift) != r_rx_s;
                        w_parity_err_n = (^r_shift) != r_rx_s;
                        w_state_n      = STOP;
                    end else begin
                        w_tcnt_n = r_tcnt + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (w_centre) begin
                        w_tcnt_n = '0;
                        if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                            w_push_n = ~r_par_bad;
`else
                            w_push_n = 1'b1;
`endif
                            w_state_n = IDLE;
                        end else begin
                            w_frame_err_n = 1'b1;
                            w_state_n     = BREAK;
                        end
                    end else begin
                        w_tcnt_n = r_tcnt + TW'(1);
                    end
                end
                BREAK: begin
                    if (r_rx_s) begin
                        w_state_n = IDLE;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    // The shift register is untouched between the stop sample and the push.
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign m_valid   = ~w_empty;
    assign w_pop     = m_valid & m_ready;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random-byte checks of uart_rx_fifo against a queue-based
// model of received bytes, FIFO occupancy and sticky overflow.
module tb_uart_rx_fifo;

    localparam int CLK_HZ  = 1600000;
    localparam int BAUD    = 100000;
    localparam int OS      = 16;
    localparam int DEPTH   = 8;
    localparam int BIT_CLK = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edge (counted from the frame's first edge) at which the good stop bit is sampled.
    localparam int PUSH_EDGE = 3 + OS / 2 + OS * (9 + PAR_BITS);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overflow;
    logic       parity_err;
    logic [3:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int n_vcyc = 0;
    int n_ferr = 0;
    int n_perr = 0;
    logic [7:0] mq[$];
    logic [7:0] recv[$];
    logic       exp_ovf = 1'b0;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .parity_err (parity_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (m_valid) n_vcyc++;
            if (m_valid && m_ready) recv.push_back(m_data);
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        mq.delete();
        recv.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (BIT_CLK) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = (^d) ^ ~par_ok;
        repeat (BIT_CLK) @(posedge clk);
`else
        if (par_ok) begin end
`endif
        #1 rx = stop;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    // Model: a good frame lands in the FIFO unless it is already full.
    task automatic model_frame(input logic [7:0] d);
        if (mq.size() >= DEPTH) exp_ovf = 1'b1;
        else mq.push_back(d);
    endtask

    task automatic compare_stream(input string tag);
        int guard;
        while (mq.size() > 0) begin
            guard = 0;
            while (recv.size() == 0 && guard < 400) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (recv.size() == 0) begin
                check({tag, "_timeout"}, recv.size(), mq.size());
                mq.delete();
            end else begin
                check(tag, recv.pop_front(), mq.pop_front());
            end
        end
        idle(4);
        check({tag, "_extra"}, recv.size(), 0);
    endtask

    initial begin
        int v0;
        int f0;
        int p0;
        logic [7:0] b;

        idle(2);
        do_reset();
        idle(32);

        // Single byte with consumer ready.
        m_ready = 1'b1;
        v0 = n_vcyc;
        f0 = n_ferr;
        model_frame(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(20);
        check("t1_valid_cycles", n_vcyc - v0, 1);
        check("t1_frame_err", n_ferr - f0, 0);
        compare_stream("t1_data");

        // Short low glitch is rejected.
        f0 = n_ferr;
        rx = 1'b0;
        idle(6);
        rx = 1'b1;
        idle(40);
        check("t2_fifo_count", fifo_count, 0);
        check("t2_recv", recv.size(), 0);
        check("t2_frame_err", n_ferr - f0, 0);

        // Bad stop bit then held-low line: one error, no bytes.
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(40 * BIT_CLK);
        check("t3_frame_err", n_ferr - f0, 1);
        check("t3_recv", recv.size(), 0);
        check("t3_fifo_count", fifo_count, 0);
        rx = 1'b1;
        idle(32);
        model_frame(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        idle(20);
        compare_stream("t3_data");

        // Random bytes.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            model_frame(b);
            send_frame(b, 1'b1, 1'b1);
            idle($urandom_range(2, 30));
            compare_stream("rand_data");
        end

        // Fill past capacity with consumer stalled.
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            model_frame(8'(i));
            send_frame(8'(i), 1'b1, 1'b1);
            idle(4);
        end
        idle(20);
        check("t4_fifo_count", fifo_count, mq.size());
        check("t4_overflow", overflow, exp_ovf);
        check("t4_m_valid", m_valid, 1);
        check("t4_head", m_data, mq[0]);
        m_ready = 1'b1;
        compare_stream("t4_drain");
        check("t4_overflow_sticky", overflow, exp_ovf);
        check("t4_empty", fifo_count, 0);

        // Full FIFO: pop on the same clock as a push.
        do_reset();
        m_ready = 1'b0;
        idle(32);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            model_frame(b);
            send_frame(b, 1'b1, 1'b1);
            idle(4);
        end
        idle(20);
        check("t5_full_count", fifo_count, mq.size());
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
                repeat (PUSH_EDGE + 1) @(posedge clk);
                #1 m_ready = 1'b1;
                @(posedge clk);
                #1 m_ready = 1'b0;
            end
        join
        mq.push_back(8'h55);
        idle(20);
        check("t5_count_kept", fifo_count, DEPTH);
        check("t5_overflow", overflow, exp_ovf);
        m_ready = 1'b1;
        compare_stream("t5_drain");

        // Reset in the middle of a frame.
        f0 = n_ferr;
        fork
            send_frame(8'hF0, 1'b1, 1'b1);
            begin
                repeat (5 * BIT_CLK + 8) @(posedge clk);
                #1 reset = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check_zero_outputs("t6_reset");
                reset = 1'b1;
            end
        join
        idle(32);
        check("t6_frame_err", n_ferr - f0, 0);
        check("t6_recv", recv.size(), 0);
        check("t6_fifo_count", fifo_count, 0);
        model_frame(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b1);
        idle(20);
        compare_stream("t6_data");

        p0 = n_perr;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(20);
        check("t6_parity_err", n_perr - p0, 1);
        check("t6_parity_recv", recv.size(), 0);
        check("t6_parity_count", fifo_count, 0);
`else
        check("parity_err_idle", n_perr - p0 + n_perr, 0);
`endif
        check("final_overflow", overflow, exp_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        bad++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
